// File: rtl/float16_pkg.sv
// Shared binary16 constants, operand classes and the iterative divider state set.
package float16_pkg;

  localparam logic [15:0] FP16_QNAN   = 16'h7E00;
  localparam logic [15:0] FP16_INF    = 16'h7C00;
  localparam int          FP16_BIAS   = 15;
  localparam int          FP16_FRAC_W = 10;
  localparam int          FP16_EXP_W  = 5;

  localparam logic signed [7:0] FP16_BIAS_S = 8'(FP16_BIAS);

  typedef enum logic [2:0] {
    FP_ZERO,
    FP_SUB,
    FP_NORM,
    FP_INF,
    FP_NAN
  } fp_class_e;

  typedef enum logic [1:0] {
    IDLE,
    DIV,
    ROUND,
    DONE
  } div_state_e;

endpackage

// File: rtl/fp16_unpack.sv
// binary16 operand classifier; subnormals are normalized to an 11-bit 1.f
// significand with the unbiased exponent lowered by the normalizing shift.
module fp16_unpack
  import float16_pkg::*;
(
  input  logic              [15:0] a,
  output logic                     sign,
  output fp_class_e                cls,
  output logic              [10:0] sig,
  output logic signed       [7:0]  e_unb
);

  logic [FP16_EXP_W-1:0]  efield;
  logic [FP16_FRAC_W-1:0] frac;
  logic [3:0]             lz;

  // Classify and normalize the operand.
  always_comb begin
    sign   = a[15];
    efield = a[14 -: FP16_EXP_W];
    frac   = a[FP16_FRAC_W-1:0];
    // Highest set fraction bit wins: it decides the shift that lands it on bit 10.
    lz = '0;
    for (int unsigned i = 0; i < FP16_FRAC_W; i++) begin
      if (frac[i]) lz = 4'(FP16_FRAC_W - i);
    end
    cls   = FP_NORM;
    sig   = {1'b1, frac};
    e_unb = $signed({3'b000, efield}) - FP16_BIAS_S;
    if (efield == '0) begin
      if (frac == '0) begin
        cls   = FP_ZERO;
        sig   = '0;
        e_unb = '0;
      end else begin
        cls   = FP_SUB;
        sig   = {1'b0, frac} << lz;
        e_unb = 8'sd1 - FP16_BIAS_S - $signed({4'b0000, lz});
      end
    end else if (efield == '1) begin
      cls = (frac == '0) ? FP_INF : FP_NAN;
    end
  end

endmodule

// File: rtl/fp16_div_iter.sv
// Iterative binary16 divider: restoring division one quotient bit per cycle,
// round-to-nearest-even. Optional macro FP16_DIV_FLAGS_EN adds the
// flags[4:0] = {invalid, divzero, overflow, underflow, inexact} output.
module fp16_div_iter
  import float16_pkg::*;
#(
  parameter int unsigned QBITS = 14
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] num1,
  input  logic [15:0] num2,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] result
`ifdef FP16_DIV_FLAGS_EN
  ,
  output logic [4:0]  flags
`endif
);

  div_state_e              state_q, state_d;
  logic [3:0]              cnt_q, cnt_d;
  logic [11:0]             rem_q, rem_d;
  logic [QBITS-1:0]        q_q, q_d;
  logic [10:0]             mb_q, mb_d;
  logic signed [7:0]       e_q, e_d;
  logic                    sign_q, sign_d;
  logic [15:0]             result_q, result_d;

  logic                    a_sign, b_sign;
  fp_class_e               a_cls, b_cls;
  logic [10:0]             a_sig, b_sig;
  logic signed [7:0]       a_exp, b_exp;

  logic                    is_special;
  logic [15:0]             spec_res, rnd_res;
  logic [11:0]             rem_t;
  logic                    q_bit;

  logic [QBITS-1:0]        qn;
  logic signed [7:0]       en, er;
  logic [10:0]             sig;
  logic                    g, st, tiny, inc;
  logic [7:0]              sh;
  logic [23:0]             wide;
  logic [11:0]             sum;

`ifdef FP16_DIV_FLAGS_EN
  logic [4:0]              flags_q, flags_d, spec_flags, rnd_flags;
  assign flags = flags_q;
`endif

  fp16_unpack u_unpack_a (.a(num1), .sign(a_sign), .cls(a_cls), .sig(a_sig), .e_unb(a_exp));
  fp16_unpack u_unpack_b (.a(num2), .sign(b_sign), .cls(b_cls), .sig(b_sig), .e_unb(b_exp));

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign result    = result_q;

  // Special-operand results, resolved in one step at accept.
  always_comb begin
    is_special = 1'b1;
    spec_res   = {a_sign ^ b_sign, 15'd0};
`ifdef FP16_DIV_FLAGS_EN
    spec_flags = '0;
`endif
    if (a_cls == FP_NAN || b_cls == FP_NAN ||
        (a_cls == FP_ZERO && b_cls == FP_ZERO) || (a_cls == FP_INF && b_cls == FP_INF)) begin
      spec_res = FP16_QNAN;
`ifdef FP16_DIV_FLAGS_EN
      spec_flags = 5'b10000;
`endif
    end else if (a_cls == FP_INF) begin
      spec_res = {a_sign ^ b_sign, FP16_INF[14:0]};
    end else if (b_cls == FP_ZERO) begin
      spec_res = {a_sign ^ b_sign, FP16_INF[14:0]};
`ifdef FP16_DIV_FLAGS_EN
      spec_flags = 5'b01000;
`endif
    end else if (a_cls == FP_ZERO || b_cls == FP_INF) begin
      spec_res = {a_sign ^ b_sign, 15'd0};
    end else begin
      is_special = 1'b0;
    end
  end

  // Normalize the raw quotient, denormalize tiny results, then round to nearest-even.
  always_comb begin
    qn   = q_q[QBITS-1] ? q_q : (q_q << 1);
    en   = q_q[QBITS-1] ? e_q : (e_q - 8'sd1);
    sig  = qn[QBITS-1 -: 11];
    g    = qn[QBITS-12];
    st   = (|qn[QBITS-13:0]) | (rem_q != '0);
    tiny = (en <= 8'sd0);
    sh   = 8'(8'sd1 - en);
    wide = '0;
    if (tiny) begin
      if (sh > 8'd12) begin
        sig = '0;
        g   = 1'b0;
        st  = 1'b1;
      end else begin
        wide = {sig, g, 12'd0} >> sh;
        sig  = wide[23:13];
        g    = wide[12];
        st   = st | (|wide[11:0]);
      end
    end
    inc = g & (st | sig[0]);
    sum = {1'b0, sig} + {11'd0, inc};
    er  = en + $signed({7'd0, sum[11]});
`ifdef FP16_DIV_FLAGS_EN
    rnd_flags = {3'b000, tiny & (g | st), g | st};
`endif
    // A subnormal that rounds up into bit 10 carries straight into exponent field 1.
    if (tiny) begin
      rnd_res = {sign_q, 4'd0, sum[10:0]};
    end else if (er >= 8'sd31) begin
      rnd_res = {sign_q, FP16_INF[14:0]};
`ifdef FP16_DIV_FLAGS_EN
      rnd_flags = 5'b00101;
`endif
    end else begin
      rnd_res = {sign_q, er[4:0], sum[9:0]};
    end
  end

  // Next-state and datapath update.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    rem_d    = rem_q;
    q_d      = q_q;
    mb_d     = mb_q;
    e_d      = e_q;
    sign_d   = sign_q;
    result_d = result_q;
`ifdef FP16_DIV_FLAGS_EN
    flags_d  = flags_q;
`endif
    rem_t    = rem_q;
    q_bit    = 1'b0;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          sign_d = a_sign ^ b_sign;
          if (is_special) begin
            result_d = spec_res;
`ifdef FP16_DIV_FLAGS_EN
            flags_d  = spec_flags;
`endif
            state_d  = DONE;
          end else begin
            rem_d   = {1'b0, a_sig};
            mb_d    = b_sig;
            q_d     = '0;
            cnt_d   = '0;
            e_d     = a_exp - b_exp + FP16_BIAS_S;
            state_d = DIV;
          end
        end
      end
      DIV: begin
        if (rem_q >= {1'b0, mb_q}) begin
          rem_t = rem_q - {1'b0, mb_q};
          q_bit = 1'b1;
        end
        rem_d = rem_t << 1;
        q_d   = {q_q[QBITS-2:0], q_bit};
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == 4'(QBITS - 1)) state_d = ROUND;
      end
      ROUND: begin
        result_d = rnd_res;
`ifdef FP16_DIV_FLAGS_EN
        flags_d  = rnd_flags;
`endif
        state_d  = DONE;
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset aborts any operation in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      rem_q    <= '0;
      q_q      <= '0;
      mb_q     <= '0;
      e_q      <= '0;
      sign_q   <= 1'b0;
      result_q <= '0;
`ifdef FP16_DIV_FLAGS_EN
      flags_q  <= '0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rem_q    <= rem_d;
      q_q      <= q_d;
      mb_q     <= mb_d;
      e_q      <= e_d;
      sign_q   <= sign_d;
      result_q <= result_d;
`ifdef FP16_DIV_FLAGS_EN
      flags_q  <= flags_d;
`endif
    end
  end

endmodule

// File: tb/tb_fp16_div_iter.sv
// Directed self-checking bench for fp16_div_iter (default build; the
// FP16_DIV_FLAGS_EN port is connected when that macro is defined).
module tb_fp16_div_iter;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] num1;
  logic [15:0] num2;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] result;
`ifdef FP16_DIV_FLAGS_EN
  logic [4:0]  flags;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  fp16_div_iter #(.QBITS(14)) dut (
    .clk(clk),
    .rst(rst),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .num1(num1),
    .num2(num2),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .result(result)
`ifdef FP16_DIV_FLAGS_EN
    ,
    .flags(flags)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // One transaction with out_ready held high; latency counted in edges after accept.
  task automatic do_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                       input logic [15:0] exp_res, input int exp_lat);
    int lat;
    @(negedge clk);
    check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    num1     = a;
    num2     = b;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    check({tag, "_result"}, 32'(result), 32'(exp_res));
    @(posedge clk);
    #1;
    check({tag, "_idle"}, 32'({in_ready, out_valid}), 32'b10);
  endtask

  initial begin
    int lat;
    int seen;
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    num1      = '0;
    num2      = '0;
    #12;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_result", 32'(result), 32'h0000);
    @(negedge clk);
    rst = 1'b0;

    do_op("two_div_one",  16'h4000, 16'h3C00, 16'h4000, 15);
    do_op("one_third",    16'h3C00, 16'h4200, 16'h3555, 15);
    do_op("neg4_div_2",   16'hC400, 16'h4000, 16'hC000, 15);
    do_op("x_div_zero",   16'h3C00, 16'h0000, 16'h7C00, 0);
    do_op("zero_zero",    16'h0000, 16'h0000, 16'h7E00, 0);
    do_op("nan_in",       16'h7E01, 16'h3C00, 16'h7E00, 0);
    do_op("zero_neg",     16'h0000, 16'hBC00, 16'h8000, 0);
    do_op("overflow",     16'h7BFF, 16'h0400, 16'h7C00, 15);
    do_op("subnorm_out",  16'h0400, 16'h4000, 16'h0200, 15);
    do_op("tie_even",     16'h0001, 16'h4000, 16'h0000, 15);
    do_op("tie_up",       16'h0003, 16'h4000, 16'h0002, 15);
    do_op("inf_div_x",    16'hFC00, 16'h4000, 16'hFC00, 0);
    do_op("x_div_inf",    16'h4000, 16'h7C00, 16'h0000, 0);

    // Backpressure: result and out_valid hold, new operands ignored in DONE.
    out_ready = 1'b0;
    @(negedge clk);
    num1     = 16'h4000;
    num2     = 16'h3C00;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check("bp_lat", 32'(lat), 32'd15);
    @(negedge clk);
    num1     = 16'h3C00;
    num2     = 16'h0000;
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      check("bp_hold_result", 32'(result), 32'h4000);
      check("bp_hold_valid", 32'({out_valid, in_ready}), 32'b10);
    end
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("bp_release", 32'({in_ready, out_valid}), 32'b10);
    check("bp_result_kept", 32'(result), 32'h4000);

    // Back-to-back: second pair offered on the cycle after DONE exit.
    do_op("b2b_first",  16'h3C00, 16'h4200, 16'h3555, 15);
    do_op("b2b_second", 16'hC400, 16'h4000, 16'hC000, 15);

    // Reset on the 7th DIV edge aborts without producing a result.
    @(negedge clk);
    num1     = 16'h3C00;
    num2     = 16'h4200;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    check("abort_busy", 32'(in_ready), 32'd0);
    repeat (6) @(posedge clk);
    @(posedge clk);
    rst = 1'b1;
    #1;
    check("abort_now", 32'({in_ready, out_valid}), 32'b10);
    @(negedge clk);
    rst  = 1'b0;
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      if (out_valid) seen++;
    end
    check("abort_no_output", 32'(seen), 32'd0);
    check("abort_idle", 32'(in_ready), 32'd1);

    do_op("after_abort", 16'h4000, 16'h3C00, 16'h4000, 15);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
